// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data RAM arbiter: default sizes and the
// encoding of the registered read-source tag.
package mem_arb_pkg;

    localparam int unsigned RamAwDefault     = 12;
    localparam int unsigned StarveMaxDefault = 4;

    typedef enum logic [1:0] {
        SrcNone  = 2'd0,
        SrcInstr = 2'd1,
        SrcData  = 2'd2
    } src_e;

endpackage

// File: rtl/mem_arb.sv
// Arbitrates one external single-port RAM between a fetch port and a data port.
// Data wins by default; a saturating counter hands the slot to fetch after STARVE_MAX data wins.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned RAM_AW     = RamAwDefault,
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_MAX);

    logic [CntW-1:0] starve_q, starve_d;
    src_e            tag_q, tag_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    // Word addressing only: byte offset and bits above the RAM are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:RAM_AW+2], i_addr[1:0],
                                d_addr[31:RAM_AW+2], d_addr[1:0]};

    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        tag_d     = SrcNone;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = d_wdata;

        if (!rst) begin
            if (d_req && !(i_req && (starve_q == StarveLim))) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end

        if (d_gnt) begin
            ram_en   = 1'b1;
            ram_addr = d_addr[RAM_AW+1:2];
            if (d_we) begin
                ram_we = d_be;
            end else begin
                tag_d = SrcData;
            end
        end else if (i_gnt) begin
            ram_en   = 1'b1;
            ram_addr = i_addr[RAM_AW+1:2];
            tag_d    = SrcInstr;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (rst || i_gnt || !i_req) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != StarveLim)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Read data passes straight through in the rvalid cycle and is held afterwards.
    always_comb begin
        i_rvalid  = !rst && (tag_q == SrcInstr);
        d_rvalid  = !rst && (tag_q == SrcData);
        i_rdata_d = i_rvalid ? ram_rdata : i_rdata_q;
        d_rdata_d = d_rvalid ? ram_rdata : d_rdata_q;
        i_rdata   = rst ? 32'h0 : i_rdata_d;
        d_rdata   = rst ? 32'h0 : d_rdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            tag_q     <= SrcNone;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            starve_q  <= starve_d;
            tag_q     <= tag_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural single-port RAM beside it.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4096];

    always #5 clk = ~clk;

    mem_arb dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        e_ign;
        logic        e_dgn;
        logic        e_en;
        logic [3:0]  e_we;
        logic [11:0] e_addr;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_be    = be;
        d_addr  = da;
        d_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ngnt;
        int nrv;
        logic exp_i;
        logic prev_i;
        logic [31:0] prev_word;
        logic [9:0] starve_pat;

        for (int k = 0; k < 4096; k++) mem[k] = 32'h1000_0000 + 32'(k);
        mem[32] = 32'h1234_5678;
        ram_rdata = 32'h0;

        tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 12'd4, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 12'd0, 1'b1, 1'b0, 32'h1000_0004, 32'h0};
        tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b1, 4'b0011, 12'd16, 1'b0, 1'b0, 32'h1000_0004, 32'h0};
        tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h42, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 12'd16, 1'b0, 1'b0, 32'h1000_0004, 32'h0};
        tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 12'd0, 1'b0, 1'b1, 32'h1000_0004, 32'h1000_BEEF};
        tbl[5]  = '{1'b1, 32'hFFFF_C008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 12'd2, 1'b0, 1'b0, 32'h1000_0004, 32'h1000_BEEF};
        tbl[6]  = '{1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'hC, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 12'd3, 1'b1, 1'b0, 32'h1000_0002, 32'h1000_BEEF};
        tbl[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'h0BAD_F00D,
                    1'b0, 1'b1, 1'b1, 4'hF, 12'd64, 1'b0, 1'b1, 32'h1000_0002, 32'h1000_0003};
        tbl[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 12'd64, 1'b0, 1'b0, 32'h1000_0002, 32'h1000_0003};
        tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 12'd0, 1'b0, 1'b1, 32'h1000_0002, 32'h0BAD_F00D};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h100, 32'h55,
                    1'b0, 1'b0, 1'b0, 4'h0, 12'd0, 1'b0, 1'b0, 32'h1000_0002, 32'h0BAD_F00D};

        // Reset with both requesters active: everything must stay quiet.
        rst = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst i_gnt", 32'(i_gnt), 32'h0);
        chk("rst d_gnt", 32'(d_gnt), 32'h0);
        chk("rst ram_en", 32'(ram_en), 32'h0);
        chk("rst ram_we", 32'(ram_we), 32'h0);
        chk("rst i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst i_rdata", i_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe, tbl[i].dbe,
                  tbl[i].daddr, tbl[i].dwd);
            @(negedge clk);
            chk($sformatf("row%0d i_gnt", i), 32'(i_gnt), 32'(tbl[i].e_ign));
            chk($sformatf("row%0d d_gnt", i), 32'(d_gnt), 32'(tbl[i].e_dgn));
            chk($sformatf("row%0d ram_en", i), 32'(ram_en), 32'(tbl[i].e_en));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
            if (tbl[i].e_en) chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            chk($sformatf("row%0d i_rvalid", i), 32'(i_rvalid), 32'(tbl[i].e_irv));
            chk($sformatf("row%0d d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].e_drv));
            chk($sformatf("row%0d i_rdata", i), i_rdata, tbl[i].e_ird);
            chk($sformatf("row%0d d_rdata", i), d_rdata, tbl[i].e_drd);
            next_cycle();
        end
        chk("store wrote word16", mem[16], 32'h1000_BEEF);

        // Starvation: both held high, fetch wins every fifth cycle.
        starve_pat = 10'b1000010000;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
            @(negedge clk);
            exp_i = starve_pat[c];
            chk($sformatf("starve c%0d i_gnt", c), 32'(i_gnt), 32'(exp_i));
            chk($sformatf("starve c%0d d_gnt", c), 32'(d_gnt), 32'(!exp_i));
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();

        // Throughput: alternating fetch/load, one grant and one rvalid every cycle.
        ngnt = 0;
        nrv = 0;
        prev_i = 1'b0;
        prev_word = 32'h0;
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                if (c % 2 == 0) drive(1'b1, 32'(4 * (c + 8)), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                else drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'(4 * (c + 40)), 32'h0);
            end else begin
                drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
            @(negedge clk);
            if (c < 8) begin
                chk($sformatf("tput c%0d i_gnt", c), 32'(i_gnt), 32'(c % 2 == 0));
                chk($sformatf("tput c%0d d_gnt", c), 32'(d_gnt), 32'(c % 2 == 1));
                if (i_gnt || d_gnt) ngnt++;
            end
            if (c > 0) begin
                chk($sformatf("tput c%0d i_rvalid", c), 32'(i_rvalid), 32'(prev_i));
                chk($sformatf("tput c%0d d_rvalid", c), 32'(d_rvalid), 32'(!prev_i));
                chk($sformatf("tput c%0d rdata", c), prev_i ? i_rdata : d_rdata, prev_word);
                if (i_rvalid || d_rvalid) nrv++;
            end
            prev_i = (c % 2 == 0);
            prev_word = 32'h1000_0000 + ((c % 2 == 0) ? 32'(c + 8) : 32'(c + 40));
            next_cycle();
        end
        chk("tput grant count", 32'(ngnt), 32'd8);
        chk("tput rvalid count", 32'(nrv), 32'd8);

        // Hold: fetched word stays on i_rdata through idle cycles.
        drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("hold i_rvalid", 32'(i_rvalid), 32'h1);
        chk("hold first i_rdata", i_rdata, 32'h1234_5678);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d i_rdata", c), i_rdata, 32'h1234_5678);
            chk($sformatf("hold c%0d ram_en", c), 32'(ram_en), 32'h0);
            next_cycle();
        end

        // Reset in the grant cycle of a load: no rvalid afterwards.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("midrst d_gnt", 32'(d_gnt), 32'h0);
        chk("midrst i_gnt", 32'(i_gnt), 32'h0);
        chk("midrst ram_en", 32'(ram_en), 32'h0);
        chk("midrst ram_we", 32'(ram_we), 32'h0);
        chk("midrst i_rdata", i_rdata, 32'h0);
        chk("midrst d_rdata", d_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("postrst d_rvalid", 32'(d_rvalid), 32'h0);
        chk("postrst i_rvalid", 32'(i_rvalid), 32'h0);
        chk("postrst i_rdata", i_rdata, 32'h0);
        chk("postrst i_gnt", 32'(i_gnt), 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("postrst fetch rdata", i_rdata, 32'h1000_0004);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
